// File: rtl/interrupt_pkg.sv
// Shared types and constants for the hart-side interrupt unit.
// Cause codes follow the machine-level mcause encoding.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HANDLER
    } state_e;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/interrupt_unit_if.sv
// Core/interruptor-facing bundle of the interrupt unit.
// The unit itself connects through the slave modport.
interface interrupt_unit_if #(
    parameter int XLEN = 32
);

    logic            i_timer_int_call;
    logic            i_software_int_call;
    logic            i_mstatus_mie;
    logic            i_mie_mtie;
    logic            i_mie_msie;
    logic [XLEN-1:0] i_mtvec;
    logic            i_instr_boundary;
    logic            i_trap_ack;
    logic            i_mret;

    logic            o_mip_mtip;
    logic            o_mip_msip;
    logic            o_trap_req;
    logic [XLEN-1:0] o_mcause;
    logic [XLEN-1:0] o_trap_vector;
    logic            o_in_handler;

    modport master (
        output i_timer_int_call,
        output i_software_int_call,
        output i_mstatus_mie,
        output i_mie_mtie,
        output i_mie_msie,
        output i_mtvec,
        output i_instr_boundary,
        output i_trap_ack,
        output i_mret,
        input  o_mip_mtip,
        input  o_mip_msip,
        input  o_trap_req,
        input  o_mcause,
        input  o_trap_vector,
        input  o_in_handler
    );

    modport slave (
        input  i_timer_int_call,
        input  i_software_int_call,
        input  i_mstatus_mie,
        input  i_mie_mtie,
        input  i_mie_msie,
        input  i_mtvec,
        input  i_instr_boundary,
        input  i_trap_ack,
        input  i_mret,
        output o_mip_mtip,
        output o_mip_msip,
        output o_trap_req,
        output o_mcause,
        output o_trap_vector,
        output o_in_handler
    );

endinterface

// File: rtl/int_priority_enc.sv
// Picks the winning enabled-pending interrupt.
// Software interrupts outrank the timer.
import interrupt_pkg::*;

module int_priority_enc (
    input  logic       msi,
    input  logic       mti,
    output logic       valid,
    output logic [3:0] code
);

    always_comb begin
        valid = 1'b0;
        code  = 4'd0;
        if (msi) begin
            valid = 1'b1;
            code  = CAUSE_MSI;
        end else if (mti) begin
            valid = 1'b1;
            code  = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/interrupt_unit.sv
// Hart-side interrupt unit: pending bits, gating, priority,
// trap request hold and in-handler blocking until mret.
import interrupt_pkg::*;

module interrupt_unit #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               arst,
    interrupt_unit_if.slave    bus
);

    state_e          state;
    logic            mip_mtip;
    logic            mip_msip;
    logic            trap_req;
    logic            in_handler;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] vector_q;

    logic            irq_valid;
    logic [3:0]      irq_code;
    logic            take;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] vec_next;
    logic [XLEN-1:0] cause_next;

    int_priority_enc u_enc (
        .msi   (mip_msip & bus.i_mie_msie),
        .mti   (mip_mtip & bus.i_mie_mtie),
        .valid (irq_valid),
        .code  (irq_code)
    );

    assign take = bus.i_mstatus_mie
                & bus.i_instr_boundary
                & irq_valid;

    assign base = {bus.i_mtvec[XLEN-1:2], 2'b00};

    // Reserved modes 2/3 fall back to direct.
    always_comb begin
        vec_next = base;
        case (bus.i_mtvec[1:0])
            MTVEC_DIRECT:   vec_next = base;
            MTVEC_VECTORED: vec_next = base + XLEN'({irq_code, 2'b00});
            default:        vec_next = base;
        endcase
    end

    assign cause_next = {1'b1, {(XLEN-5){1'b0}}, irq_code};

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= IDLE;
            mip_mtip   <= 1'b0;
            mip_msip   <= 1'b0;
            trap_req   <= 1'b0;
            in_handler <= 1'b0;
            mcause_q   <= '0;
            vector_q   <= '0;
        end else begin
            mip_mtip <= bus.i_timer_int_call;
            mip_msip <= bus.i_software_int_call;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        state    <= REQ;
                        trap_req <= 1'b1;
                        mcause_q <= cause_next;
                        vector_q <= vec_next;
                    end
                end
                REQ: begin
                    if (bus.i_trap_ack) begin
                        state      <= HANDLER;
                        trap_req   <= 1'b0;
                        in_handler <= 1'b1;
                    end
                end
                HANDLER: begin
                    if (bus.i_mret) begin
                        state      <= IDLE;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_mip_mtip    = mip_mtip;
    assign bus.o_mip_msip    = mip_msip;
    assign bus.o_trap_req    = trap_req;
    assign bus.o_mcause      = mcause_q;
    assign bus.o_trap_vector = vector_q;
    assign bus.o_in_handler  = in_handler;

endmodule

// File: tb/tb_interrupt_unit.sv
// Self-checking bench for interrupt_unit.
// Expected traps are queued at stimulus time and popped on o_trap_req.
module tb_interrupt_unit;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    interrupt_unit_if #(.XLEN(32)) bus ();

    interrupt_unit #(.XLEN(32)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inputs_idle();
        bus.i_timer_int_call    = 1'b0;
        bus.i_software_int_call = 1'b0;
        bus.i_mstatus_mie       = 1'b0;
        bus.i_mie_mtie          = 1'b0;
        bus.i_mie_msie          = 1'b0;
        bus.i_mtvec             = 32'h0;
        bus.i_instr_boundary    = 1'b0;
        bus.i_trap_ack          = 1'b0;
        bus.i_mret              = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.i_trap_ack = 1'b1;
        tick();
        bus.i_trap_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        bus.i_mret = 1'b1;
        tick();
        bus.i_mret = 1'b0;
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            ok = bus.o_trap_req;
        end
    endtask

    task automatic retire_trap();
        pulse_ack();
        bus.i_timer_int_call    = 1'b0;
        bus.i_software_int_call = 1'b0;
        tick();
        tick();
        pulse_mret();
        tick();
    endtask

    task automatic test_reset();
        inputs_idle();
        arst = 1'b0;
        bus.i_timer_int_call    = 1'b1;
        bus.i_software_int_call = 1'b1;
        bus.i_mstatus_mie       = 1'b1;
        bus.i_mie_mtie          = 1'b1;
        bus.i_mie_msie          = 1'b1;
        bus.i_instr_boundary    = 1'b1;
        tick();
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0)
            $display("FAIL rst_req: got %b want 0", bus.o_trap_req);
        else passed++;
        total++;
        if (bus.o_in_handler !== 1'b0)
            $display("FAIL rst_hnd: got %b want 0", bus.o_in_handler);
        else passed++;
        total++;
        if ({bus.o_mip_mtip, bus.o_mip_msip} !== 2'b00)
            $display("FAIL rst_mip: got %b%b want 00",
                     bus.o_mip_mtip, bus.o_mip_msip);
        else passed++;
        total++;
        if (bus.o_mcause !== 32'h0 || bus.o_trap_vector !== 32'h0)
            $display("FAIL rst_cause_vec: got %h/%h want 0/0",
                     bus.o_mcause, bus.o_trap_vector);
        else passed++;
        inputs_idle();
        arst = 1'b1;
        tick();
    endtask

    task automatic test_timer_direct();
        exp_t e;
        bus.i_mtvec          = 32'h0000_0100;
        bus.i_mstatus_mie    = 1'b1;
        bus.i_mie_mtie       = 1'b1;
        bus.i_mie_msie       = 1'b0;
        bus.i_instr_boundary = 1'b1;
        exp_q.push_back('{32'h8000_0007, 32'h0000_0100});
        bus.i_timer_int_call = 1'b1;
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0 || bus.o_mip_mtip !== 1'b1)
            $display("FAIL td_edge1: got req=%b mtip=%b want 0/1",
                     bus.o_trap_req, bus.o_mip_mtip);
        else passed++;
        tick();
        total++;
        if (bus.o_trap_req !== 1'b1)
            $display("FAIL td_edge2_req: got %b want 1", bus.o_trap_req);
        else passed++;
        total++;
        if (exp_q.size() == 0)
            $display("FAIL td_sb: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL td_cause_vec: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        pulse_ack();
        total++;
        if (bus.o_trap_req !== 1'b0 || bus.o_in_handler !== 1'b1)
            $display("FAIL td_ack: got req=%b hnd=%b want 0/1",
                     bus.o_trap_req, bus.o_in_handler);
        else passed++;
        bus.i_timer_int_call = 1'b0;
        tick();
        tick();
        pulse_mret();
        total++;
        if (bus.o_in_handler !== 1'b0)
            $display("FAIL td_mret: got %b want 0", bus.o_in_handler);
        else passed++;
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0)
            $display("FAIL td_quiet: got %b want 0", bus.o_trap_req);
        else passed++;
    endtask

    task automatic test_sw_vectored();
        exp_t e;
        bus.i_mtvec          = 32'h0000_0201;
        bus.i_mstatus_mie    = 1'b1;
        bus.i_mie_mtie       = 1'b1;
        bus.i_mie_msie       = 1'b1;
        bus.i_instr_boundary = 1'b1;
        exp_q.push_back('{32'h8000_0003, 32'h0000_020C});
        exp_q.push_back('{32'h8000_0007, 32'h0000_021C});
        bus.i_timer_int_call    = 1'b1;
        bus.i_software_int_call = 1'b1;
        tick();
        tick();
        total++;
        if (bus.o_trap_req !== 1'b1)
            $display("FAIL sv_req: got %b want 1", bus.o_trap_req);
        else passed++;
        total++;
        if (exp_q.size() == 0)
            $display("FAIL sv_sb_msi: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL sv_msi: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        pulse_ack();
        total++;
        if (bus.o_in_handler !== 1'b1 || bus.o_mip_mtip !== 1'b1)
            $display("FAIL sv_hnd: got hnd=%b mtip=%b want 1/1",
                     bus.o_in_handler, bus.o_mip_mtip);
        else passed++;
        bus.i_software_int_call = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0)
            $display("FAIL sv_blocked: got %b want 0", bus.o_trap_req);
        else passed++;
        pulse_mret();
        total++;
        if (bus.o_in_handler !== 1'b0 || bus.o_trap_req !== 1'b0)
            $display("FAIL sv_mret: got hnd=%b req=%b want 0/0",
                     bus.o_in_handler, bus.o_trap_req);
        else passed++;
        tick();
        total++;
        if (bus.o_trap_req !== 1'b1)
            $display("FAIL sv_mti_req: got %b want 1", bus.o_trap_req);
        else passed++;
        total++;
        if (exp_q.size() == 0)
            $display("FAIL sv_sb_mti: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL sv_mti: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        retire_trap();
    endtask

    task automatic test_masking();
        exp_t e;
        bus.i_mtvec          = 32'h0000_0100;
        bus.i_mstatus_mie    = 1'b0;
        bus.i_mie_mtie       = 1'b1;
        bus.i_mie_msie       = 1'b0;
        bus.i_instr_boundary = 1'b1;
        bus.i_timer_int_call = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0 || bus.o_mip_mtip !== 1'b1)
            $display("FAIL mk_mie0: got req=%b mtip=%b want 0/1",
                     bus.o_trap_req, bus.o_mip_mtip);
        else passed++;
        bus.i_instr_boundary = 1'b0;
        bus.i_mstatus_mie    = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0)
            $display("FAIL mk_noboundary: got %b want 0", bus.o_trap_req);
        else passed++;
        exp_q.push_back('{32'h8000_0007, 32'h0000_0100});
        bus.i_instr_boundary = 1'b1;
        tick();
        total++;
        if (bus.o_trap_req !== 1'b1)
            $display("FAIL mk_boundary: got %b want 1", bus.o_trap_req);
        else passed++;
        total++;
        if (exp_q.size() == 0)
            $display("FAIL mk_sb: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL mk_cause_vec: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        retire_trap();
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        bus.i_mtvec          = 32'h0000_0100;
        bus.i_mstatus_mie    = 1'b1;
        bus.i_mie_mtie       = 1'b1;
        bus.i_mie_msie       = 1'b0;
        bus.i_instr_boundary = 1'b1;
        exp_q.push_back('{32'h8000_0007, 32'h0000_0100});
        bus.i_timer_int_call = 1'b1;
        wait_req(6, ok);
        total++;
        if (ok !== 1'b1)
            $display("FAIL hd_wait: got no req want req");
        else passed++;
        bus.i_timer_int_call = 1'b0;
        bus.i_mtvec          = 32'h0000_0301;
        bus.i_mstatus_mie    = 1'b0;
        bus.i_mie_mtie       = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (bus.o_trap_req !== 1'b1)
            $display("FAIL hd_noretract: got %b want 1", bus.o_trap_req);
        else passed++;
        total++;
        if (exp_q.size() == 0)
            $display("FAIL hd_sb: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL hd_stable: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        pulse_ack();
        total++;
        if (bus.o_trap_req !== 1'b0 || bus.o_in_handler !== 1'b1)
            $display("FAIL hd_ack: got req=%b hnd=%b want 0/1",
                     bus.o_trap_req, bus.o_in_handler);
        else passed++;
        bus.i_mtvec       = 32'h0000_0100;
        bus.i_mstatus_mie = 1'b1;
        bus.i_mie_mtie    = 1'b1;
        pulse_mret();
        tick();
    endtask

    task automatic test_ack_mret_same();
        exp_t e;
        bit   ok;
        exp_q.push_back('{32'h8000_0007, 32'h0000_0100});
        bus.i_timer_int_call = 1'b1;
        wait_req(6, ok);
        total++;
        if (ok !== 1'b1)
            $display("FAIL am_wait: got no req want req");
        else if (exp_q.size() == 0)
            $display("FAIL am_sb: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL am_cause_vec: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        bus.i_trap_ack = 1'b1;
        bus.i_mret     = 1'b1;
        tick();
        bus.i_trap_ack = 1'b0;
        bus.i_mret     = 1'b0;
        total++;
        if (bus.o_in_handler !== 1'b1 || bus.o_trap_req !== 1'b0)
            $display("FAIL am_both: got hnd=%b req=%b want 1/0",
                     bus.o_in_handler, bus.o_trap_req);
        else passed++;
        bus.i_timer_int_call = 1'b0;
        tick();
        tick();
        total++;
        if (bus.o_in_handler !== 1'b1)
            $display("FAIL am_stay: got %b want 1", bus.o_in_handler);
        else passed++;
        pulse_mret();
        total++;
        if (bus.o_in_handler !== 1'b0)
            $display("FAIL am_mret1: got %b want 0", bus.o_in_handler);
        else passed++;
        pulse_mret();
        tick();
        total++;
        if (bus.o_in_handler !== 1'b0 || bus.o_trap_req !== 1'b0)
            $display("FAIL am_mret2: got hnd=%b req=%b want 0/0",
                     bus.o_in_handler, bus.o_trap_req);
        else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        bus.i_mtvec             = 32'h0000_0100;
        bus.i_mstatus_mie       = 1'b1;
        bus.i_mie_mtie          = 1'b1;
        bus.i_mie_msie          = 1'b1;
        bus.i_instr_boundary    = 1'b1;
        bus.i_timer_int_call    = 1'b1;
        bus.i_software_int_call = 1'b1;
        wait_req(6, ok);
        total++;
        if (ok !== 1'b1)
            $display("FAIL rm_wait: got no req want req");
        else passed++;
        pulse_ack();
        total++;
        if (bus.o_in_handler !== 1'b1)
            $display("FAIL rm_hnd: got %b want 1", bus.o_in_handler);
        else passed++;
        #2;
        arst = 1'b0;
        #1;
        total++;
        if ({bus.o_trap_req, bus.o_in_handler,
             bus.o_mip_mtip, bus.o_mip_msip} !== 4'b0000)
            $display("FAIL rm_async: got req=%b hnd=%b mip=%b%b want 0000",
                     bus.o_trap_req, bus.o_in_handler,
                     bus.o_mip_mtip, bus.o_mip_msip);
        else passed++;
        total++;
        if (bus.o_mcause !== 32'h0 || bus.o_trap_vector !== 32'h0)
            $display("FAIL rm_async_cv: got %h/%h want 0/0",
                     bus.o_mcause, bus.o_trap_vector);
        else passed++;
        tick();
        arst = 1'b1;
        exp_q.push_back('{32'h8000_0003, 32'h0000_0100});
        tick();
        total++;
        if (bus.o_trap_req !== 1'b0 || bus.o_mip_msip !== 1'b1)
            $display("FAIL rm_edge1: got req=%b msip=%b want 0/1",
                     bus.o_trap_req, bus.o_mip_msip);
        else passed++;
        tick();
        total++;
        if (bus.o_trap_req !== 1'b1)
            $display("FAIL rm_edge2: got %b want 1", bus.o_trap_req);
        else if (exp_q.size() == 0)
            $display("FAIL rm_sb: got empty queue want entry");
        else begin
            e = exp_q.pop_front();
            if ({bus.o_mcause, bus.o_trap_vector} !== e)
                $display("FAIL rm_cause_vec: got %h/%h want %h/%h",
                         bus.o_mcause, bus.o_trap_vector, e.cause, e.vec);
            else passed++;
        end
        retire_trap();
    endtask

    initial begin
        inputs_idle();
        arst = 1'b0;
        test_reset();
        test_timer_direct();
        test_sw_vectored();
        test_masking();
        test_hold();
        test_ack_mret_same();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0)
            $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/interrupt_unit.md
# interrupt_unit

Hart-side consumer of the core-local interruptor's timer and software interrupt lines. It registers the raw request levels into pending bits (mip.MTIP/MSIP) and gates them with enables (mie, mstatus.MIE). At an instruction boundary it picks the highest-priority enabled request, computes mcause and the trap target from mtvec, and holds a trap request to the pipeline until acknowledged. It then blocks further interrupts until mret.

## Interface
- `XLEN`, default 32: width of mtvec, vector and mcause.
- `clk`  in  1  system clock; all state on rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `i_timer_int_call`  in  1  level timer request from interruptor (mtime >= mtimecmp).
- `i_software_int_call`  in  1  level software request from interruptor (msip != 0).
- `i_mstatus_mie`  in  1  global machine interrupt enable.
- `i_mie_mtie` / `i_mie_msie`  in  1 each  per-source enables.
- `i_mtvec`  in  XLEN  trap vector CSR; [1:0] = mode.
- `i_instr_boundary`  in  1  core can accept a trap this cycle.
- `i_trap_ack`  in  1  core has redirected to `o_trap_vector`.
- `i_mret`  in  1  mret retired this cycle.
- `o_mip_mtip` / `o_mip_msip`  out  1 each  registered pending bits.
- `o_trap_req`  out  1  interrupt trap request.
- `o_mcause`  out  XLEN  `{1'b1, zeros, code}`; valid while `o_trap_req`.
- `o_trap_vector`  out  XLEN  trap target; valid while `o_trap_req`.
- `o_in_handler`  out  1  high from ack until mret.

## Operation
- Reset value of every output is 0. The state is IDLE and the pending bits are 0.
- Pending bits register the raw lines every cycle. They are levels with no sticky capture; the source clears them.
- `take` = `i_mstatus_mie` & `i_instr_boundary` & ((`o_mip_msip` & `i_mie_msie`) | (`o_mip_mtip` & `i_mie_mtie`)).
- Priority: MSI (code 3) over MTI (code 7).
- mtvec mode 0 (direct): vector = {mtvec[XLEN-1:2], 2'b00}.
- mtvec mode 1 (vectored): vector = base + 4*code, computed modulo 2^XLEN.
- mtvec modes 2 and 3 are treated as direct.
- FSM states:
  - IDLE: on `take`, latch code, mcause and vector, then go to REQ. `i_trap_ack` and `i_mret` are ignored.
  - REQ: `o_trap_req` = 1. Latched cause and vector are held stable regardless of source, enable or mtvec changes; there is no retraction. On `i_trap_ack`, go to HANDLER.
  - HANDLER: `o_in_handler` = 1 and no new trap is taken. On `i_mret`, go to IDLE.
- Simultaneous events:
  - `i_trap_ack` and `i_mret` in REQ: ack wins, go to HANDLER, mret is ignored.
  - `i_mret` with an enabled request pending in HANDLER: go to IDLE. The request is evaluated on the next cycle.
  - Both sources pending and enabled in IDLE: MSI is taken. MTI remains pending for after mret.
- Reset mid-operation (any state): asynchronous return to IDLE with all outputs 0.

## Timing
- Source line rises at edge N, so the pending bit is high after edge N+1.
- If `take` holds in that cycle, `o_trap_req` is high after edge N+2. Minimum latency is 2 cycles.
- Ack sampled at edge M: `o_trap_req` is low and `o_in_handler` is high after edge M.
- mret sampled at edge K: `o_in_handler` is low after K. Earliest next `o_trap_req` is after K+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `interrupt_pkg`:
  - state enum {IDLE, REQ, HANDLER};
  - `CAUSE_MSI` = 4'd3 and `CAUSE_MTI` = 4'd7;
  - mtvec mode constants `MTVEC_DIRECT` = 2'b00 and `MTVEC_VECTORED` = 2'b01.
- One sub-module, `int_priority_enc`: a combinational encoder from enabled-pending bits to {valid, code}.

## Test plan
- Timer direct: mtvec=0x0000_0100, MIE=1, MTIE=1, timer line high, boundary held high → `o_trap_req` after 2 edges, mcause=0x8000_0007, vector=0x0000_0100. Ack → `o_in_handler`=1.
- Software vectored, both sources high: mtvec=0x0000_0201, both enables set → mcause=0x8000_0003, vector=0x0000_020C. After mret, timer taken with vector 0x0000_021C.
- Masking:
  - MIE=0 with timer high → no request and `o_mip_mtip`=1.
  - Set MIE=1 with boundary low → no request until boundary.
- Hold stability: in REQ, drop the timer line and rewrite mtvec → mcause and vector unchanged until ack.
- Ack and mret in the same cycle while in REQ → HANDLER. A later mret returns to IDLE; a second mret is ignored.
- Reset asserted in HANDLER while requests pend → all outputs 0 immediately. After release, a trap is re-requested 2 edges later.
